// File: rtl/pos_rom_arbiter_pkg.sv
// Shared definitions for the positional-embedding ROM arbiter and its users.
package tva_pos_pkg;

  localparam int FP16_W         = 16;
  localparam int DEF_NUM_TOKENS = 196;
  localparam int DEF_E          = 128;
  localparam int ID_W           = 4;

  // One tracking slot per ROM latency cycle; the id is wide enough for 16 requesters.
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            err;
  } pos_req_tag_t;

endpackage

// File: rtl/pos_rom_arbiter_if.sv
// Requester-side bus of the positional ROM arbiter: flattened requests in, one-hot grant and response out.
interface pos_rom_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int TW         = 8,
  parameter int DW         = 7,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*TW-1:0] req_token;
  logic [NUM_REQ*DW-1:0] req_dim;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  modport master (
    output req_valid, req_token, req_dim,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_token, req_dim,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/pos_rom_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid index at or after ptr, with wrap.
module rr_picker #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_cand;
  logic          w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_cand = IW'((int'(i_ptr) + k) % N);
      if (!w_found && i_valid[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/pos_rom_arbiter.sv
// Round-robin sharing of one positional ROM read port, with a latency-matched tag pipeline
// that returns each word to its requester as a registered one-hot response.
module pos_rom_arbiter
  import tva_pos_pkg::*;
#(
  parameter  int DATA_WIDTH = FP16_W,
  parameter  int NUM_TOKENS = DEF_NUM_TOKENS,
  parameter  int E          = DEF_E,
  parameter  int NUM_REQ    = 4,
  parameter  int ROM_LAT    = 1,
  localparam int TW         = $clog2(NUM_TOKENS),
  localparam int DW         = $clog2(E),
  localparam int IW         = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  pos_rom_arbiter_if.slave      bus,
  output logic [TW-1:0]         rom_token,
  output logic [DW-1:0]         rom_dim,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  err_sticky,
  output logic                  busy
);

  localparam logic [TW:0] TOK_LIM = (TW+1)'(NUM_TOKENS);
  localparam logic [DW:0] DIM_LIM = (DW+1)'(E);

  logic [NUM_REQ-1:0]    w_grant;
  logic [IW-1:0]         w_idx;
  logic                  w_any;
  logic                  w_go;
  logic [TW-1:0]         w_tok;
  logic [DW-1:0]         w_dim;
  logic                  w_err;
  logic                  w_pipe_busy;
  logic [NUM_REQ-1:0]    w_tail_oh;
  pos_req_tag_t          w_tag_in;
  pos_req_tag_t          w_tail;

  logic [IW-1:0]         r_ptr;
  logic [TW-1:0]         r_last_tok;
  logic [DW-1:0]         r_last_dim;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_err;
  logic                  r_err_sticky;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .i_valid (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_go          = enable & w_any;
  assign bus.req_ready = enable ? w_grant : '0;

  assign w_tok = bus.req_token[w_idx*TW +: TW];
  assign w_dim = bus.req_dim[w_idx*DW +: DW];
  assign w_err = ({1'b0, w_tok} >= TOK_LIM) || ({1'b0, w_dim} >= DIM_LIM);

  // Idle cycles replay the last granted address so the ROM inputs stay quiet.
  assign rom_token = w_go ? w_tok : r_last_tok;
  assign rom_dim   = w_go ? w_dim : r_last_dim;

  assign w_tag_in = {w_go, ID_W'(w_idx), w_err};

  // Grant stage -> ROM latency tracking
  generate
    if (ROM_LAT == 0) begin : g_bypass
      assign w_tail      = w_tag_in;
      assign w_pipe_busy = 1'b0;
    end else begin : g_pipe
      pos_req_tag_t r_pipe [ROM_LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < ROM_LAT; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= w_tag_in;
          for (int i = 1; i < ROM_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      always_comb begin
        w_pipe_busy = 1'b0;
        for (int i = 0; i < ROM_LAT; i++) w_pipe_busy = w_pipe_busy | r_pipe[i].valid;
      end

      assign w_tail = r_pipe[ROM_LAT-1];
    end
  endgenerate

  assign w_tail_oh = NUM_REQ'(1) << w_tail.id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_last_tok <= '0;
      r_last_dim <= '0;
    end else if (w_go) begin
      r_ptr      <= (int'(w_idx) == NUM_REQ-1) ? '0 : w_idx + 1'b1;
      r_last_tok <= w_tok;
      r_last_dim <= w_dim;
    end
  end

  // Tail of tracking pipeline -> response register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_rsp_valid  <= w_tail.valid ? w_tail_oh : '0;
      r_rsp_err    <= w_tail.valid & w_tail.err;
      if (w_tail.valid) r_rsp_data <= w_tail.err ? '0 : rom_data;
      r_err_sticky <= r_err_sticky | (w_go & w_err);
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign err_sticky    = r_err_sticky;
  assign busy          = w_pipe_busy | (|r_rsp_valid);

endmodule

// File: doc/pos_rom_arbiter.md
# pos_rom_arbiter

Round-robin arbiter that shares one FP16 positional-embedding ROM read port between NUM_REQ requesters. Typical requesters are parallel embedding-add lanes or heads that each need PosROM[token, dim]. Each cycle the block grants at most one request, drives the ROM address, and tracks the request through the ROM's fixed read latency. It then returns the data to the granted requester, tagged one-hot. It sits between the lane datapaths and positional_encoding_rom_fp16, which is instantiated outside this block.

## Interface
- DATA_WIDTH, 16, ROM word width (FP16)
- NUM_TOKENS, 196, token rows in ROM
- E, 128, embedding dimension (ROM columns)
- NUM_REQ, 4, number of requesters (2..16)
- ROM_LAT, 1, ROM read latency in cycles (0..4; 0 = combinational ROM)
- TW = $clog2(NUM_TOKENS), DW = $clog2(E): derived localparams

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  grant enable; when low, no new grants and the pipeline drains
- req_valid  in  NUM_REQ  per-requester request
- req_token  in  NUM_REQ*TW  flattened; requester r at [r*TW +: TW]
- req_dim  in  NUM_REQ*DW  flattened; requester r at [r*DW +: DW]
- req_ready  out  NUM_REQ  one-hot grant (combinational); a request is accepted when req_valid[r] && req_ready[r]
- rom_token  out  TW  ROM token address
- rom_dim  out  DW  ROM dim address
- rom_data  in  DATA_WIDTH  ROM data, valid ROM_LAT cycles after address
- rsp_valid  out  NUM_REQ  one-hot response strobe, registered
- rsp_data  out  DATA_WIDTH  response data, registered
- rsp_err  out  1  response carries an out-of-range address; qualified by |rsp_valid
- err_sticky  out  1  set by any out-of-range grant, cleared only by reset
- busy  out  1  any request in flight in the latency pipeline

## Operation
- Priority pointer `ptr` (0..NUM_REQ-1):
  - Grant goes to the first r with req_valid[r], scanning ptr, ptr+1, … with wrap at NUM_REQ.
  - Only when enable=1.
  - req_ready[r]=1 only for the granted r; all zero if none valid or enable=0.
- On a grant to r, ptr <= (r+1) mod NUM_REQ. With no grant, ptr holds.
- rom_token/rom_dim are combinational muxes of the granted requester's fields. When there is no grant they hold the last granted address, so ROM inputs do not toggle.
- Range check on the grant: req_token >= NUM_TOKENS or req_dim >= E is out of range.
  - The ROM is still addressed with the raw value.
  - The response returns rsp_data = 0 with rsp_err = 1.
  - err_sticky <= 1.
- Tracking pipeline is a shift register of depth ROM_LAT holding {valid, id, err}. It is advanced every cycle; there is no backpressure and responses must be consumed when presented.
- Response register, loaded from the pipeline tail with rom_data:
  - rsp_valid = onehot(id) when the tail is valid, else 0.
  - rsp_data = err ? 0 : rom_data.
  - When there is no response, rsp_data holds its previous value.
- busy = OR of the pipeline valid bits plus the response register valid.
- Reset values:
  - req-side logic is combinational and follows its inputs.
  - ptr = 0.
  - Pipeline valid bits all cleared; in-flight requests are discarded with no response.
  - rsp_valid = 0, rsp_data = 0, rsp_err = 0, err_sticky = 0, busy = 0.
  - rom_token = 0, rom_dim = 0 until the first grant.

## Timing
- Grant in cycle T, ROM data at T+ROM_LAT, rsp_valid asserted in cycle T+ROM_LAT+1 (registered).
- Throughput is one grant per cycle, back to back. Requesters may change token/dim every granted cycle.
- A requester that stays valid is regranted at the latest every NUM_REQ cycles while others also request (fairness bound).
- enable falling in cycle T: no grant in T; already granted requests still return their responses.
- Reset asserted mid-stream: all outputs are at reset values asynchronously. The first grant after release uses ptr = 0.
- A single requester with all others idle gets a grant every cycle.

## Structure
- Shared package `tva_pos_pkg`:
  - FP16 width constant.
  - Default NUM_TOKENS/E.
  - A `pos_req_tag_t` struct {valid, id, err} for the tracking pipeline.
- Sub-module `rr_picker #(N)`: combinational round-robin picker from valid and ptr to a one-hot grant plus encoded index. The later attention scheduler reuses it.
- ROM latency pipeline is a generate loop in the top (ROM_LAT=0 bypasses it).

## Test plan
- Reset, then req_valid=4'b0001, token=5, dim=7, ROM_LAT=1:
  - req_ready=0001 the same cycle.
  - rsp_valid=0001 two cycles later, rsp_data = ROM[5][7], rsp_err=0.
- All four requesters valid continuously for 8 cycles: grant order 0,1,2,3,0,1,2,3, and the responses follow in the same order with matching data.
- ptr=2 (after granting r1), req_valid=1011: grants 3, then 0, then 1; requester 2 is never granted.
- Requester 1 with token=196 (NUM_TOKENS): rsp_valid=0010, rsp_data=0, rsp_err=1, err_sticky stays 1 afterward.
- enable dropped for 3 cycles with all requesters valid: req_ready=0 for those 3 cycles, in-flight responses still arrive, busy falls to 0.
- Reset asserted while 2 requests are in flight:
  - rsp_valid never pulses for them.
  - The first grant after release goes to the lowest valid index.
